uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
Bluetooth UART byte receiver feeding the robot remote-control command decoder. It samples the serial line from the HC-05 module (routed through an IR sensor pin), frames 8N1 bytes, and holds the last good byte as the command word. It flags framing errors and a link-loss timeout so the downstream motor logic can fall back to rest. It replaces the opaque receive wrapper in front of the left/right speed command registers.

Parameters:
CLKS_PER_BIT, 1667, WF_CLK cycles per UART bit (16 MHz / 9600 baud); must be >= 4.
TIMEOUT_CYC, 16000000, WF_CLK cycles without a good byte before link_lost asserts (1 s).

Ports:
WF_CLK  input  1  system clock, all logic on rising edge
WF_BUTTON  input  1  reset, asynchronous, active-low
rx  input  1  raw UART line, idle high, asynchronous to WF_CLK
data  output  8  last correctly framed byte, held until the next good byte
data_valid  output  1  one-cycle pulse when data updates
frame_err  output  1  sticky; last received frame had a bad stop bit
link_lost  output  1  no good byte within TIMEOUT_CYC cycles

Behaviour:
- Reset (WF_BUTTON low, async): data=8'h00, data_valid=0, frame_err=0, link_lost=1, FSM=IDLE, all counters 0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
- Bit counter clk_cnt, width $clog2(CLKS_PER_BIT); bit_idx 0..7; shift register filled LSB first.
- FSM:
  - IDLE: rx_s==0 -> START, clk_cnt=0.
  - START: count to CLKS_PER_BIT/2-1 (integer divide); at that cycle rx_s==0 -> DATA, clk_cnt=0, bit_idx=0; rx_s==1 -> IDLE (glitch rejected, no flags).
  - DATA: count to CLKS_PER_BIT-1; on that cycle shift in rx_s, clk_cnt=0; after bit_idx==7 -> STOP, else bit_idx+1.
  - STOP: count to CLKS_PER_BIT-1; sample rx_s. If 1: data<=shift, data_valid=1 next cycle, frame_err<=0, -> IDLE. If 0: data unchanged, no pulse, frame_err<=1, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE (a held-low line does not retrigger).
- data_valid is high for exactly one cycle per good byte; it is registered and coincides with the first cycle data shows the new value.
- Latency: the falling edge of rx reaches data_valid in 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, +/-1 for edge alignment.
- Back-to-back frames (stop bit followed immediately by a start bit) must be received without loss. The FSM reaches IDLE mid-stop-bit.
- Timeout counter: width $clog2(TIMEOUT_CYC+1).
  - Cleared to 0 and link_lost<=0 in the cycle data_valid is asserted.
  - Otherwise increments, saturating at TIMEOUT_CYC-1. On reaching it, link_lost<=1 and stays until the next good byte.
  - Framing errors do not clear the counter.
- Reset asserted mid-frame aborts the frame immediately to reset values. After release, a partially seen frame is treated as a fresh line: a low line enters START and must still pass the mid-bit check.
- No parity, no FIFO. A byte arriving before the consumer reads the previous one simply overwrites data; the consumer samples on data_valid.

Test Plan:
Bench parameters: CLKS_PER_BIT=16, TIMEOUT_CYC=1000.
1. Reset, line idle 200 cycles -> data=8'h00, data_valid=0, frame_err=0, link_lost=1.
2. Send 8'hA5 at 16 cycles/bit -> exactly one data_valid pulse, data=8'hA5, link_lost=0, frame_err=0.
3. Send 8'hC3 then 8'h3C back-to-back (no idle gap) -> two pulses, data=8'hC3 then 8'h3C.
4. 3-cycle low glitch on rx -> no data_valid, data unchanged, FSM back to IDLE. Then send 8'hFF with stop bit forced 0 and held low 50 cycles -> frame_err=1, data unchanged, no retrigger. Then send 8'h81 -> data=8'h81, frame_err=0.
5. After byte 8'h7E, keep line idle 1000 cycles -> link_lost rises at cycle 999 after the pulse. Send 8'h01 -> link_lost=0.
6. Pull WF_BUTTON low during bit 4 of 8'h55 -> outputs return to reset values asynchronously. Release and send 8'h55 -> data=8'h55.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// 8N1 UART byte receiver for the remote-control command path.
// Holds the last good byte and flags framing errors and link-loss timeout.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 1667,
  parameter int unsigned TIMEOUT_CYC  = 16000000
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       link_lost
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q;
  logic            data_valid_q, frame_err_q, link_lost_q, link_lost_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            half_done, bit_done, good_byte, bad_stop;

  assign half_done = (clk_cnt_q == HalfLast);
  assign bit_done  = (clk_cnt_q == BitLast);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rx_s) state_d = StStart;
      StStart: if (half_done) state_d = rx_s ? StIdle : StData;
      StData:  if (bit_done && bit_idx_q == 3'd7) state_d = StStop;
      // Leaving at mid-stop-bit keeps back-to-back frames aligned.
      StStop:  if (bit_done) state_d = rx_s ? StIdle : StBreak;
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    good_byte = 1'b0;
    bad_stop  = 1'b0;
    unique case (state_q)
      StIdle: clk_cnt_d = '0;
      StStart: begin
        if (half_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          good_byte = rx_s;
          bad_stop  = !rx_s;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StBreak: clk_cnt_d = '0;
      default: clk_cnt_d = '0;
    endcase
  end

  // Counter clears alongside the data_valid pulse; framing errors leave it running.
  always_comb begin
    if (good_byte) begin
      tmo_d       = '0;
      link_lost_d = 1'b0;
    end else begin
      tmo_d       = (tmo_q == TmoLast) ? tmo_q : tmo_q + TmoW'(1);
      link_lost_d = link_lost_q | (tmo_d == TmoLast);
    end
  end

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      link_lost_q  <= 1'b1;
      tmo_q        <= '0;
    end else begin
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_valid_q <= good_byte;
      link_lost_q  <= link_lost_d;
      tmo_q        <= tmo_d;
      if (good_byte) data_q <= shift_q;
      if (good_byte)     frame_err_q <= 1'b0;
      else if (bad_stop) frame_err_q <= 1'b1;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign link_lost  = link_lost_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed scenarios plus random frames
// compared against a frame-level model of expected bytes, flags and timeout.
module tb_uart_cmd_rx;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Tmo = 1000;

  logic       WF_CLK;
  logic       WF_BUTTON;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       link_lost;

  uart_cmd_rx #(
    .CLKS_PER_BIT(Cpb),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .WF_CLK    (WF_CLK),
    .WF_BUTTON (WF_BUTTON),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .link_lost (link_lost)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_pulse_cyc = 0;
  bit         seen_good = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  logic       exp_fe;

  initial WF_CLK = 1'b0;
  always #5 WF_CLK = ~WF_CLK;

  always @(posedge WF_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Collects pulses and checks link_lost every cycle: high until the first good
  // byte, then high once TIMEOUT_CYC-1 cycles have elapsed since the last pulse.
  always @(negedge WF_CLK) begin
    if (!WF_BUTTON) begin
      seen_good = 0;
    end else if (data_valid) begin
      got_q.push_back(data);
      seen_good      = 1;
      last_pulse_cyc = cyc;
    end
    chk("link_lost_track", 32'(link_lost),
        32'(!seen_good || (cyc - last_pulse_cyc >= int'(Tmo) - 1)));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge WF_CLK);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    idle(n);
  endtask

  // Sends one 8N1 frame with the given stop level and updates the model.
  task automatic tx(input logic [7:0] b, input logic stop);
    logic [7:0] v;
    int         start_cyc;
    v = b;
    start_cyc = cyc;
    drive_bit(1'b0, Cpb);
    for (int i = 0; i < 8; i++) drive_bit(v[i], Cpb);
    drive_bit(stop, Cpb);
    if (stop) begin
      exp_q.push_back(b);
      exp_data = b;
      exp_fe   = 1'b0;
      chk("latency", 32'((last_pulse_cyc - start_cyc >= 154) &&
                         (last_pulse_cyc - start_cyc <= 156)), 32'd1);
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_data"}, 32'(data), 32'(exp_data));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_fe));
    chk({tag, "_npulse"}, 32'(got_q.size()), 32'(exp_q.size()));
    if (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_last"}, 32'(got_q[$]), 32'(exp_q[$]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    logic       rgood;
    int         gap;

    // 1: reset and idle line
    WF_BUTTON = 1'b0;
    rx        = 1'b1;
    exp_data  = 8'h00;
    exp_fe    = 1'b0;
    idle(5);
    WF_BUTTON = 1'b1;
    idle(200);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_link_lost", 32'(link_lost), 32'd1);

    // 2: single byte
    tx(8'hA5, 1'b1);
    idle(3);
    check_state("a5");
    chk("a5_link_lost", 32'(link_lost), 32'd0);

    // 3: back-to-back frames
    tx(8'hC3, 1'b1);
    check_state("c3");
    tx(8'h3C, 1'b1);
    idle(3);
    check_state("3c");

    // 4: glitch, bad stop with held-low line, then recovery
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    check_state("glitch");
    tx(8'hFF, 1'b0);
    idle(50);
    check_state("bad_stop");
    drive_bit(1'b1, 10);
    check_state("break_exit");
    tx(8'h81, 1'b1);
    idle(3);
    check_state("81");

    // 5: link-loss timeout
    tx(8'h7E, 1'b1);
    check_state("7e");
    while (cyc < last_pulse_cyc + int'(Tmo) - 2) @(negedge WF_CLK);
    chk("tmo_before", 32'(link_lost), 32'd0);
    @(negedge WF_CLK);
    chk("tmo_at", 32'(link_lost), 32'd1);
    idle(20);
    tx(8'h01, 1'b1);
    idle(3);
    check_state("01");
    chk("tmo_cleared", 32'(link_lost), 32'd0);

    // 6: reset in the middle of bit 4 of 8'h55
    drive_bit(1'b0, Cpb);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, Cpb);
    drive_bit(1'b1, Cpb / 2);
    #3 WF_BUTTON = 1'b0;
    #1;
    chk("abort_data", 32'(data), 32'h00);
    chk("abort_valid", 32'(data_valid), 32'd0);
    chk("abort_frame_err", 32'(frame_err), 32'd0);
    chk("abort_link_lost", 32'(link_lost), 32'd1);
    exp_data = 8'h00;
    exp_fe   = 1'b0;
    idle(1);
    drive_bit(1'b1, 20);
    WF_BUTTON = 1'b1;
    idle(40);
    check_state("post_abort");
    tx(8'h55, 1'b1);
    idle(3);
    check_state("55");

    // Random frames: random bytes, occasional bad stop, random gaps incl. none
    for (int n = 0; n < 15; n++) begin
      rb    = 8'($urandom);
      rgood = ($urandom_range(0, 4) != 0);
      tx(rb, rgood);
      if (!rgood) begin
        idle($urandom_range(0, 20));
        drive_bit(1'b1, 4);
      end
      check_state("rand");
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
      if (gap > 0) idle(gap);
    end
    idle(20);

    chk("stream_size", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk("stream_byte", 32'(got_q[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
